// File: rtl/vga_capture.sv
// VGA receive side: samples sync/rgb on the pixel strobe, recovers line/frame
// counters, verifies timing and emits captured active pixels once locked.
module vga_capture #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_START  = 145,
  parameter int unsigned V_START  = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [11:0] px_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_FIRST = CW'(H_START);
  localparam logic [CW-1:0] H_END   = CW'(H_START + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_FIRST = CW'(V_START);
  localparam logic [CW-1:0] V_END   = CW'(V_START + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_hs;
  logic            r_vs;
  logic [11:0]     r_rgb;
  logic [CW-1:0]   r_hcnt;
  logic [CW-1:0]   r_vcnt;
  logic            r_vs_seen;

  logic            w_hs_fall;
  logic            w_vs_fall;
  logic            w_vzero;
  logic            w_line_err;
  logic            w_frame_err;
  logic            w_err;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_capture;
  logic [CW-1:0]   w_x;
  logic [CW-1:0]   w_y;

  // Edge detection compares the stored sample with the one being taken now.
  assign w_hs_fall   = p_tick & r_hs & ~hsync;
  assign w_vs_fall   = p_tick & r_vs & ~vsync;
  // A vsync fall coincident with the hsync fall still zeroes the line count.
  assign w_vzero     = w_hs_fall & (r_vs_seen | w_vs_fall);
  assign w_line_err  = w_hs_fall & (r_state != S_SEARCH) & (r_hcnt != H_LAST);
  assign w_frame_err = w_vzero & (r_state != S_SEARCH) & (r_vcnt != V_LAST);
  assign w_err       = w_line_err | w_frame_err;

  assign w_h_act   = (r_hcnt >= H_FIRST) && (r_hcnt <= H_END);
  assign w_v_act   = (r_vcnt >= V_FIRST) && (r_vcnt <= V_END);
  assign w_capture = p_tick & (r_state == S_LOCKED) & ~w_err & w_h_act & w_v_act;
  assign w_x       = r_hcnt - H_FIRST;
  assign w_y       = r_vcnt - V_FIRST;

  // Lock state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_SEARCH;
    else        r_state <= w_state_next;
  end

  // Lock next-state: two clean frame boundaries to lock, any failed check drops out.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SEARCH:  if (w_vzero) w_state_next = S_MEASURE;
      S_MEASURE: begin
        if (w_err)        w_state_next = S_SEARCH;
        else if (w_vzero) w_state_next = S_LOCKED;
      end
      S_LOCKED:  if (w_err) w_state_next = S_SEARCH;
      default:   w_state_next = S_SEARCH;
    endcase
  end

  // Stage 1: sample sync and colour on the pixel strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else if (p_tick) begin
      r_hs  <= hsync;
      r_vs  <= vsync;
      r_rgb <= rgb;
    end
  end

  // Saturating position counters and the vsync-seen flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_vs_seen <= 1'b0;
    end else if (p_tick) begin
      if (w_hs_fall) begin
        r_hcnt    <= '0;
        r_vs_seen <= 1'b0;
        if (r_vs_seen | w_vs_fall) r_vcnt <= '0;
        else if (r_vcnt != CNT_MAX) r_vcnt <= r_vcnt + CW'(1);
      end else begin
        if (r_hcnt != CNT_MAX) r_hcnt <= r_hcnt + CW'(1);
        if (w_vs_fall) r_vs_seen <= 1'b1;
      end
    end
  end

  // Stage 2: registered pixel, status and error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      px_valid    <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= w_err;
      locked      <= (w_state_next == S_LOCKED);
      if (w_capture) begin
        px_valid    <= 1'b1;
        px_x        <= w_x;
        px_y        <= w_y;
        px_rgb      <= r_rgb;
        frame_start <= (w_x == '0) && (w_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using reduced timing so whole frames fit in a short run.
module tb_vga_capture;

  localparam int HT  = 24;
  localparam int VT  = 10;
  localparam int HA  = 8;
  localparam int VA  = 4;
  localparam int HS  = 7;
  localparam int VS  = 3;
  localparam int HSW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rgb = '0;
  logic        px_valid;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [11:0] px_rgb;
  logic        frame_start;
  logic        locked;
  logic        timing_err;

  vga_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_START(HS), .V_START(VS)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int f_err, f_px, f_fs, bad_range;
  logic [3:0] corners;

  // Reference model: positions derived from sample indices of the last sync falls.
  int m_n, m_lastfall, m_lastvfall, m_lines, m_phase;
  logic m_prev_hs, m_prev_vs;
  logic [11:0] m_prev_rgb;
  logic e_valid, e_err, e_fs;
  int e_x, e_y;
  logic [11:0] e_rgb;

  typedef struct {
    int   lines;
    int   short_line;
    int   exp_err;
    int   exp_px;
    int   exp_fs;
    logic exp_locked;
  } frame_vec_t;

  frame_vec_t vecs[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_lastfall = -1; m_lastvfall = -2; m_lines = 0; m_phase = 0;
    m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_prev_rgb = '0;
    e_valid = 0; e_err = 0; e_fs = 0; e_x = 0; e_y = 0; e_rgb = '0;
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic [11:0] c);
    logic hf, vf, zero;
    int hc_old, vc_old, ph_old;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    hc_old = m_n - 1 - m_lastfall;
    if (hc_old > 1023) hc_old = 1023;
    vc_old = m_lines;
    ph_old = m_phase;
    e_err = 0;
    if (vf) m_lastvfall = m_n;
    if (hf) begin
      zero = (m_lastvfall > m_lastfall);
      if (ph_old != 0 && hc_old != HT - 1) e_err = 1;
      if (zero && ph_old != 0 && vc_old != VT - 1) e_err = 1;
      if (e_err) m_phase = 0;
      else if (zero && m_phase < 2) m_phase = m_phase + 1;
      m_lines = zero ? 0 : ((vc_old + 1 > 1023) ? 1023 : vc_old + 1);
      m_lastfall = m_n;
    end
    e_valid = (ph_old == 2) && !e_err && hc_old >= HS && hc_old < HS + HA &&
              vc_old >= VS && vc_old < VS + VA;
    e_fs = 0;
    if (e_valid) begin
      e_x = hc_old - HS;
      e_y = vc_old - VS;
      e_rgb = m_prev_rgb;
      e_fs = (e_x == 0) && (e_y == 0);
    end
    m_prev_hs = hs; m_prev_vs = vs; m_prev_rgb = c;
    m_n++;
  endtask

  // One clock: drive at negedge, check just after posedge.
  task automatic cycle(input logic pt, input logic hs, input logic vs, input logic [11:0] c);
    @(negedge clk);
    p_tick = pt; hsync = hs; vsync = vs; rgb = c;
    if (pt) model_step(hs, vs, c);
    else begin e_valid = 0; e_err = 0; e_fs = 0; end
    @(posedge clk); #1;
    chk("px_valid", px_valid, e_valid);
    chk("timing_err", timing_err, e_err);
    chk("frame_start", frame_start, e_fs);
    chk("locked", locked, m_phase == 2);
    chk("px_x", px_x, e_x);
    chk("px_y", px_y, e_y);
    chk("px_rgb", px_rgb, e_rgb);
    f_err += timing_err; f_px += px_valid; f_fs += frame_start;
    if (px_valid) begin
      if (px_x >= HA || px_y >= VA) bad_range++;
      if (px_x == 0      && px_y == 0)      corners[0] = 1'b1;
      if (px_x == HA - 1 && px_y == 0)      corners[1] = 1'b1;
      if (px_x == 0      && px_y == VA - 1) corners[2] = 1'b1;
      if (px_x == HA - 1 && px_y == VA - 1) corners[3] = 1'b1;
    end
  endtask

  // One pixel sample preceded by 0..2 idle clocks carrying glitches.
  task automatic sample(input logic hs, input logic vs, input logic [11:0] c);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) cycle(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
    cycle(1'b1, hs, vs, c);
  endtask

  task automatic send_frame(input int lines, input int short_line, input int voff);
    int len;
    logic vs;
    f_err = 0; f_px = 0; f_fs = 0;
    for (int v = 0; v < lines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        if (voff == 0) vs = (v >= 2);
        else vs = !((v == 0 && h >= voff) || (v == 1 && h < voff));
        sample(h >= HSW, vs, 12'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{10, -1, 0, 0,  0, 1'b0};
    vecs[1] = '{10, -1, 0, 32, 1, 1'b1};
    vecs[2] = '{10, -1, 0, 32, 1, 1'b1};
    vecs[3] = '{10,  5, 1, 24, 1, 1'b0};
    vecs[4] = '{9,  -1, 0, 0,  0, 1'b0};
    vecs[5] = '{10, -1, 1, 0,  0, 1'b0};
    vecs[6] = '{10, -1, 0, 0,  0, 1'b0};
    vecs[7] = '{10, -1, 0, 32, 1, 1'b1};

    model_reset();
    bad_range = 0; corners = '0;
    #12;
    chk("reset_locked", locked, 0);
    chk("reset_px_valid", px_valid, 0);
    chk("reset_timing_err", timing_err, 0);
    chk("reset_px_x", px_x, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].lines, vecs[i].short_line, 0);
      chk($sformatf("frame%0d_err", i), f_err, vecs[i].exp_err);
      chk($sformatf("frame%0d_px", i), f_px, vecs[i].exp_px);
      chk($sformatf("frame%0d_fs", i), f_fs, vecs[i].exp_fs);
      chk($sformatf("frame%0d_locked", i), locked, vecs[i].exp_locked);
    end
    chk("corners_seen", corners, 4'hF);
    chk("out_of_range_px", bad_range, 0);

    // Reset right after pixel (0,0) while locked.
    send_frame(3, -1, 0);
    for (int h = 0; h <= HS + 1; h++) sample(h >= HSW, 1'b1, 12'($urandom));
    chk("pre_reset_px_valid", px_valid, 1);
    chk("pre_reset_locked", locked, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_locked", locked, 0);
    chk("async_reset_px_valid", px_valid, 0);
    @(negedge clk);
    p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    send_frame(10, -1, 5);
    chk("relock_first_locked", locked, 0);
    chk("relock_first_px", f_px, 0);
    send_frame(10, -1, 5);
    chk("relock_second_locked", locked, 1);
    chk("relock_second_px", f_px, 32);
    chk("relock_second_fs", f_fs, 1);

    // No sync at all.
    do_reset();
    f_err = 0; f_px = 0; f_fs = 0;
    for (int i = 0; i < 1100; i++) sample(1'b1, 1'b1, 12'($urandom));
    chk("nosync_hcnt_sat", dut.r_hcnt, 1023);
    chk("nosync_locked", locked, 0);
    chk("nosync_px", f_px, 0);
    chk("nosync_err", f_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
